mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Consumer end of the EX_Stage output interface: registers EX results, performs the data-memory
//  access (store/load), selects ALU vs memory data and drives the register-file write port.
//  Sits between EX_Stage and the register file; also exports forwarding/hazard info to ID/EX.
//  Data words are complex: [15:8] real byte, [7:0] imaginary byte (opaque here, no arithmetic).
// PARAMETERS
//  DATA_W      16  data word width (ALU_Result, Data_B, memory word)
//  REG_ADDR_W  8   destination register address width (C_Reg)
//  MEM_ADDR_W  8   data memory address bits; depth = 2**MEM_ADDR_W words
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           asynchronous, active-high reset
//  stall          in   1           EX not producing a result this cycle (divider busy) -> bubble
//  MWE_In         in   1           memory write enable (store) from EX
//  Mux_In         in   1           1 = writeback from memory (load), 0 = from ALU_Result
//  RWE_In         in   1           register write enable from EX
//  ALU_Result_In  in   DATA_W      ALU result; low MEM_ADDR_W bits are the memory address
//  Data_B_In      in   DATA_W      store data
//  C_Reg_In       in   REG_ADDR_W  destination register
//  RF_WE          out  1           register-file write enable
//  RF_Addr        out  REG_ADDR_W  register-file write address
//  RF_Data        out  DATA_W      register-file write data
//  Fwd_M_Valid    out  1           M-register holds an instruction with RWE=1
//  Fwd_M_IsLoad   out  1           that instruction is a load (data not yet available; ID must stall)
//  Fwd_M_Addr     out  REG_ADDR_W  its destination register
//  Fwd_M_Data     out  DATA_W      its ALU result (valid only when Fwd_M_IsLoad=0)
//  Retired_Count  out  16          count of committed register writes + stores, wraps 0xFFFF->0
// BEHAVIOUR
//  Pipeline: M register (ctrl+data) then W register. Latency EX presentation -> RF_* = 2 clocks.
//  - Cycle N: EX presents. Posedge end N: if stall=0 capture inputs into M; if stall=1 capture bubble
//    (MWE=RWE=Mux=0, data regs don't-care, hold old values).
//  - Cycle N+1: memory addressed by M.ALU_Result[MEM_ADDR_W-1:0]. If M.MWE: mem[addr] <= M.Data_B
//    at posedge end N+1. Load data read combinationally from array during N+1, captured into W.
//  - Cycle N+2: RF_WE=W.RWE, RF_Addr=W.C_Reg, RF_Data = W.Mux ? loaded word : W.ALU_Result.
//  - One instruction per stage, so memory never sees read and write in the same cycle.
//  - Store followed immediately by load of same address: load returns the stored word.
//  - MWE and RWE both 1: store and register write both performed (no conflict).
//  - Mux_In=1 with RWE_In=0: load performs no register write, no count.
//  - Retired_Count += 1 at posedge end N+1 when M.MWE or M.RWE (at most +1 per cycle).
//  Reset (async, immediate): M and W ctrl bits cleared -> RF_WE=0, RF_Addr=0, RF_Data=0,
//    Fwd_M_*=0, Retired_Count=0. Store pending in M at reset is NOT committed. Memory contents not
//    reset (undefined until written). First capture on first posedge after rst deasserts.
//  No backpressure: this stage never stalls EX; it always accepts.
// TESTING
//  1 ALU writeback: ALU_Result_In=0x0A0C, RWE=1, Mux=0, C_Reg=0x05, stall=0 -> 2 clocks later
//    RF_WE=1, RF_Addr=0x05, RF_Data=0x0A0C; Retired_Count=1.
//  2 Store then load: store ALU_Result=0x0055, Data_B=0x0050 (MWE=1,RWE=0); next cycle load
//    ALU_Result=0x0055, Mux=1, RWE=1, C_Reg=0x07 -> RF_Data=0x0050, RF_Addr=0x07, RF_WE=1; count +2.
//  3 Divider stall: hold stall=1 for 8 clocks with RWE_In=1 -> RF_WE=0 throughout, count unchanged;
//    drop stall with result 0x0F01 -> RF_Data=0x0F01 two clocks later, exactly one write.
//  4 Forwarding: load in M -> Fwd_M_Valid=1, Fwd_M_IsLoad=1; ALU op in M -> IsLoad=0,
//    Fwd_M_Data=ALU_Result.
//  5 Reset mid-store: assert rst while store to 0x10 (data 0x1234) sits in M -> outputs 0
//    immediately; after release, load 0x10 does not return 0x1234 unless a prior write did.
//  6 Counter wrap: preload via 65535 writes (or force) -> next commit gives Retired_Count=0x0000.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: registers EX results (M), performs the data-memory access,
// then registers the writeback (W) that drives the register-file write port.
module mem_wb_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 8,
    parameter int MEM_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  MWE_In,
    input  logic                  Mux_In,
    input  logic                  RWE_In,
    input  logic [DATA_W-1:0]     ALU_Result_In,
    input  logic [DATA_W-1:0]     Data_B_In,
    input  logic [REG_ADDR_W-1:0] C_Reg_In,
    output logic                  RF_WE,
    output logic [REG_ADDR_W-1:0] RF_Addr,
    output logic [DATA_W-1:0]     RF_Data,
    output logic                  Fwd_M_Valid,
    output logic                  Fwd_M_IsLoad,
    output logic [REG_ADDR_W-1:0] Fwd_M_Addr,
    output logic [DATA_W-1:0]     Fwd_M_Data,
    output logic [15:0]           Retired_Count
);

    localparam int DEPTH = 1 << MEM_ADDR_W;

    logic                  m_mwe_q, m_mwe_d;
    logic                  m_mux_q, m_mux_d;
    logic                  m_rwe_q, m_rwe_d;
    logic [DATA_W-1:0]     m_alu_q, m_alu_d;
    logic [DATA_W-1:0]     m_datab_q, m_datab_d;
    logic [REG_ADDR_W-1:0] m_creg_q, m_creg_d;

    logic                  w_rwe_q, w_rwe_d;
    logic                  w_mux_q, w_mux_d;
    logic [REG_ADDR_W-1:0] w_creg_q, w_creg_d;
    logic [DATA_W-1:0]     w_alu_q, w_alu_d;
    logic [DATA_W-1:0]     w_load_q, w_load_d;

    logic [15:0]           retired_q, retired_d;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_rdata;

    always_comb begin
        // A stalled EX cycle enters M as a bubble; data fields keep their old values.
        m_mwe_d   = 1'b0;
        m_mux_d   = 1'b0;
        m_rwe_d   = 1'b0;
        m_alu_d   = m_alu_q;
        m_datab_d = m_datab_q;
        m_creg_d  = m_creg_q;
        if (!stall) begin
            m_mwe_d   = MWE_In;
            m_mux_d   = Mux_In;
            m_rwe_d   = RWE_In;
            m_alu_d   = ALU_Result_In;
            m_datab_d = Data_B_In;
            m_creg_d  = C_Reg_In;
        end

        mem_addr  = m_alu_q[MEM_ADDR_W-1:0];
        mem_rdata = mem[mem_addr];

        w_rwe_d   = m_rwe_q;
        w_mux_d   = m_mux_q;
        w_creg_d  = m_creg_q;
        w_alu_d   = m_alu_q;
        w_load_d  = mem_rdata;

        retired_d = retired_q + {15'd0, (m_mwe_q | m_rwe_q)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mwe_q   <= 1'b0;
            m_mux_q   <= 1'b0;
            m_rwe_q   <= 1'b0;
            m_alu_q   <= '0;
            m_datab_q <= '0;
            m_creg_q  <= '0;
            w_rwe_q   <= 1'b0;
            w_mux_q   <= 1'b0;
            w_creg_q  <= '0;
            w_alu_q   <= '0;
            w_load_q  <= '0;
            retired_q <= '0;
        end else begin
            m_mwe_q   <= m_mwe_d;
            m_mux_q   <= m_mux_d;
            m_rwe_q   <= m_rwe_d;
            m_alu_q   <= m_alu_d;
            m_datab_q <= m_datab_d;
            m_creg_q  <= m_creg_d;
            w_rwe_q   <= w_rwe_d;
            w_mux_q   <= w_mux_d;
            w_creg_q  <= w_creg_d;
            w_alu_q   <= w_alu_d;
            w_load_q  <= w_load_d;
            retired_q <= retired_d;
        end
    end

    // Memory contents are not reset; a store in M is dropped by reset because m_mwe_q clears.
    always_ff @(posedge clk) begin
        if (m_mwe_q) begin
            mem[mem_addr] <= m_datab_q;
        end
    end

    assign RF_WE         = w_rwe_q;
    assign RF_Addr       = w_creg_q;
    assign RF_Data       = w_mux_q ? w_load_q : w_alu_q;
    assign Fwd_M_Valid   = m_rwe_q;
    assign Fwd_M_IsLoad  = m_rwe_q & m_mux_q;
    assign Fwd_M_Addr    = m_creg_q;
    assign Fwd_M_Data    = m_alu_q;
    assign Retired_Count = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: table vectors, hand sequences for multi-cycle cases,
// and randomized traffic against a sequential instruction-level memory/RF model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b1;
    logic        MWE_In = 1'b0, Mux_In = 1'b0, RWE_In = 1'b0;
    logic [15:0] ALU_Result_In = '0, Data_B_In = '0;
    logic [7:0]  C_Reg_In = '0;
    logic        RF_WE, Fwd_M_Valid, Fwd_M_IsLoad;
    logic [7:0]  RF_Addr, Fwd_M_Addr;
    logic [15:0] RF_Data, Fwd_M_Data, Retired_Count;

    int errors = 0;
    int checks = 0;

    mem_wb_stage #(.DATA_W(16), .REG_ADDR_W(8), .MEM_ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .MWE_In(MWE_In), .Mux_In(Mux_In), .RWE_In(RWE_In),
        .ALU_Result_In(ALU_Result_In), .Data_B_In(Data_B_In), .C_Reg_In(C_Reg_In),
        .RF_WE(RF_WE), .RF_Addr(RF_Addr), .RF_Data(RF_Data),
        .Fwd_M_Valid(Fwd_M_Valid), .Fwd_M_IsLoad(Fwd_M_IsLoad),
        .Fwd_M_Addr(Fwd_M_Addr), .Fwd_M_Data(Fwd_M_Data),
        .Retired_Count(Retired_Count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, mwe, mux, rwe;
        logic [15:0] alu, datab;
        logic [7:0]  creg;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [15:0] exp_data, exp_cnt;
    } vec_t;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        dknown;
        logic [15:0] cnt;
    } exp_t;

    vec_t        tbl[8];
    exp_t        q[$];
    logic [15:0] mem_m [256];
    bit          known [256];
    logic [15:0] cnt_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic mwe, input logic mux, input logic rwe,
                         input logic [15:0] alu, input logic [15:0] db, input logic [7:0] cr);
        stall = st; MWE_In = mwe; Mux_In = mux; RWE_In = rwe;
        ALU_Result_In = alu; Data_B_In = db; C_Reg_In = cr;
    endtask

    task automatic bubble();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 8'h0);
    endtask

    task automatic do_reset();
        bubble();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " RF_WE"}, 32'(RF_WE), 32'd0);
        chk({tag, " RF_Addr"}, 32'(RF_Addr), 32'd0);
        chk({tag, " RF_Data"}, 32'(RF_Data), 32'd0);
        chk({tag, " Fwd_Valid"}, 32'(Fwd_M_Valid), 32'd0);
        chk({tag, " Fwd_IsLoad"}, 32'(Fwd_M_IsLoad), 32'd0);
        chk({tag, " Fwd_Addr"}, 32'(Fwd_M_Addr), 32'd0);
        chk({tag, " Fwd_Data"}, 32'(Fwd_M_Data), 32'd0);
        chk({tag, " count"}, 32'(Retired_Count), 32'd0);
    endtask

    initial begin
        logic [15:0] c0;
        // Reset state, checked while reset is held
        #1;
        chk_zero("reset");
        step();
        step();
        chk_zero("reset_held");
        rst = 1'b0;

        // Reset arriving while a store to 0x10 sits in M
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, 8'h00);
        step();
        bubble();
        rst = 1'b1;
        #1;
        chk_zero("rst_mid_store");
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 8'h03);
        step();
        bubble();
        step();
        chk("post_rst_load_we", 32'(RF_WE), 32'd1);
        checks++;
        if (RF_Data === 16'h1234) begin
            errors++;
            $display("FAIL post_rst_load_data: got %h required anything but 1234", RF_Data);
        end
        chk("post_rst_count", 32'(Retired_Count), 32'd1);

        // Table vectors: each instruction followed by a bubble, counts absolute after reset
        do_reset();
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0A0C, 16'h0000, 8'h05, 1'b1, 8'h05, 16'h0A0C, 16'd1};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0055, 16'h0050, 8'h00, 1'b0, 8'h00, 16'h0000, 16'd2};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0055, 16'h0000, 8'h07, 1'b1, 8'h07, 16'h0050, 16'd3};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0055, 16'h0000, 8'h08, 1'b0, 8'h00, 16'h0000, 16'd3};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0030, 16'hBEEF, 8'h09, 1'b1, 8'h09, 16'h0030, 16'd4};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0130, 16'h0000, 8'h0A, 1'b1, 8'h0A, 16'hBEEF, 16'd5};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h0000, 8'h0B, 1'b0, 8'h00, 16'h0000, 16'd5};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 8'hFF, 1'b1, 8'hFF, 16'hFFFF, 16'd6};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].stall, tbl[i].mwe, tbl[i].mux, tbl[i].rwe,
                  tbl[i].alu, tbl[i].datab, tbl[i].creg);
            step();
            bubble();
            step();
            chk($sformatf("tbl%0d RF_WE", i), 32'(RF_WE), 32'(tbl[i].exp_we));
            if (tbl[i].exp_we) begin
                chk($sformatf("tbl%0d RF_Addr", i), 32'(RF_Addr), 32'(tbl[i].exp_addr));
                chk($sformatf("tbl%0d RF_Data", i), 32'(RF_Data), 32'(tbl[i].exp_data));
            end
            chk($sformatf("tbl%0d count", i), 32'(Retired_Count), 32'(tbl[i].exp_cnt));
        end

        // Store immediately followed by a load of the same address
        c0 = Retired_Count;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0066, 16'h0050, 8'h00);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0066, 16'h0000, 8'h07);
        step();
        bubble();
        step();
        chk("st_ld RF_WE", 32'(RF_WE), 32'd1);
        chk("st_ld RF_Addr", 32'(RF_Addr), 32'h07);
        chk("st_ld RF_Data", 32'(RF_Data), 32'h0050);
        chk("st_ld count", 32'(Retired_Count), 32'(c0 + 16'd2));

        // Divider stall for 8 clocks with RWE asserted, then one real result
        c0 = Retired_Count;
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0BAD, 16'h0000, 8'h0E);
            step();
            chk($sformatf("stall%0d RF_WE", i), 32'(RF_WE), 32'd0);
        end
        chk("stall count", 32'(Retired_Count), 32'(c0));
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0F01, 16'h0000, 8'h0E);
        step();
        bubble();
        chk("stall_rel RF_WE early", 32'(RF_WE), 32'd0);
        step();
        chk("stall_rel RF_WE", 32'(RF_WE), 32'd1);
        chk("stall_rel RF_Data", 32'(RF_Data), 32'h0F01);
        step();
        chk("stall_rel single write", 32'(RF_WE), 32'd0);
        chk("stall_rel count", 32'(Retired_Count), 32'(c0 + 16'd1));

        // Forwarding view of the M register
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0022, 16'h0000, 8'h0B);
        step();
        chk("fwd_ld valid", 32'(Fwd_M_Valid), 32'd1);
        chk("fwd_ld isload", 32'(Fwd_M_IsLoad), 32'd1);
        chk("fwd_ld addr", 32'(Fwd_M_Addr), 32'h0B);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1357, 16'h0000, 8'h0C);
        step();
        chk("fwd_alu valid", 32'(Fwd_M_Valid), 32'd1);
        chk("fwd_alu isload", 32'(Fwd_M_IsLoad), 32'd0);
        chk("fwd_alu addr", 32'(Fwd_M_Addr), 32'h0C);
        chk("fwd_alu data", 32'(Fwd_M_Data), 32'h1357);
        bubble();
        step();
        chk("fwd_bubble valid", 32'(Fwd_M_Valid), 32'd0);
        step();

        // Randomized traffic vs. sequential model: each instruction reads memory, then stores
        do_reset();
        cnt_m = 16'd0;
        for (int a = 0; a < 256; a++) known[a] = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            exp_t        e;
            logic [7:0]  a;
            logic [15:0] rd;
            bit          kn;
            drive(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  {8'($urandom), 8'h40 + 8'($urandom_range(0, 15))}, 16'($urandom), 8'($urandom));
            e = '{1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000};
            if (!stall) begin
                a  = ALU_Result_In[7:0];
                rd = mem_m[a];
                kn = known[a];
                if (MWE_In) begin
                    mem_m[a] = Data_B_In;
                    known[a] = 1'b1;
                end
                e.we     = RWE_In;
                e.addr   = C_Reg_In;
                e.data   = Mux_In ? rd : ALU_Result_In;
                e.dknown = Mux_In ? kn : 1'b1;
                if (MWE_In || RWE_In) cnt_m = cnt_m + 16'd1;
            end
            e.cnt = cnt_m;
            q.push_back(e);
            step();
            chk("rnd fwd valid", 32'(Fwd_M_Valid), 32'(!stall && RWE_In));
            if (!stall && RWE_In) begin
                chk("rnd fwd isload", 32'(Fwd_M_IsLoad), 32'(Mux_In));
                chk("rnd fwd addr", 32'(Fwd_M_Addr), 32'(C_Reg_In));
                if (!Mux_In) chk("rnd fwd data", 32'(Fwd_M_Data), 32'(ALU_Result_In));
            end
            if (q.size() == 2) begin
                e = q.pop_front();
                chk("rnd RF_WE", 32'(RF_WE), 32'(e.we));
                chk("rnd count", 32'(Retired_Count), 32'(e.cnt));
                if (e.we) begin
                    chk("rnd RF_Addr", 32'(RF_Addr), 32'(e.addr));
                    if (e.dknown) chk("rnd RF_Data", 32'(RF_Data), 32'(e.data));
                end
            end
        end
        q.delete();

        // Counter wrap: 65535 commits reach 0xFFFF, the next one wraps to 0
        do_reset();
        for (int k = 0; k < 65535; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 16'(k), 16'h0000, 8'(k));
            step();
        end
        bubble();
        step();
        chk("wrap count_ffff", 32'(Retired_Count), 32'hFFFF);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hA5A5, 16'h0000, 8'h11);
        step();
        bubble();
        step();
        chk("wrap count_0", 32'(Retired_Count), 32'h0000);
        chk("wrap RF_Data", 32'(RF_Data), 32'hA5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
